// File: rtl/serial_frame_ctrl.sv
// Frame sequencer behind the serial start-flag detector: captures address and length
// fields MSB first, routes L payload bits to one port, then releases the detector.
module serial_frame_ctrl #(
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   serIn,
    input  logic                   collectvalid,
    output logic                   detect,
    output logic                   busy,
    output logic [2**ADDR_W-1:0]   port_valid,
    output logic                   port_bit,
    output logic [ADDR_W-1:0]      addr_q,
    output logic [LEN_W-1:0]       len_q,
    output logic                   done
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int CNT_MAX = max3(ADDR_W, LEN_W, 2**LEN_W - 1);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [LEN_W-1:0] len_next;
    logic             in_data;

    assign cnt_inc  = cnt + 1'b1;
    // The DATA/DONE decision must see the length including the bit arriving now.
    assign len_next = LEN_W'({len_q, serIn});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            busy    <= 1'b0;
            detect  <= 1'b0;
            done    <= 1'b0;
            in_data <= 1'b0;
        end else begin
            detect <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (collectvalid) begin
                        state <= ADDR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ADDR: begin
                    addr_q <= ADDR_W'({addr_q, serIn});
                    if (cnt_inc == CNT_W'(ADDR_W)) begin
                        state <= LEN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LEN: begin
                    len_q <= len_next;
                    if (cnt_inc == CNT_W'(LEN_W)) begin
                        cnt <= '0;
                        if (len_next == '0) begin
                            state  <= DONE;
                            detect <= 1'b1;
                            done   <= 1'b1;
                        end else begin
                            state   <= DATA;
                            in_data <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DATA: begin
                    if (cnt_inc == CNT_W'(len_q)) begin
                        state   <= DONE;
                        in_data <= 1'b0;
                        detect  <= 1'b1;
                        done    <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    in_data <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

    always_comb begin
        port_valid = '0;
        if (in_data) begin
            port_valid[addr_q] = 1'b1;
        end
    end

    assign port_bit = in_data & serIn;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: directed vector table, hand sequences and random frames,
// all checked each cycle against a frame-offset reference model.
module tb_serial_frame_ctrl;

    localparam int AW = 2;
    localparam int LW = 4;
    localparam int NP = 4;
    localparam int D0 = AW + LW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          serIn;
    logic          collectvalid;
    logic          detect;
    logic          busy;
    logic [NP-1:0] port_valid;
    logic          port_bit;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] len_q;
    logic          done;

    serial_frame_ctrl #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .serIn       (serIn),
        .collectvalid(collectvalid),
        .detect      (detect),
        .busy        (busy),
        .port_valid  (port_valid),
        .port_bit    (port_bit),
        .addr_q      (addr_q),
        .len_q       (len_q),
        .done        (done)
    );

    always #5 clk = ~clk;

    int vec_cnt   = 0;
    int miss      = 0;
    int done_seen = 0;

    // Model: frame offset from the collectvalid cycle (-1 = idle) plus field values.
    int m_off  = -1;
    int m_addr = 0;
    int m_len  = 0;

    logic          s_busy, s_done, s_pbit;
    logic [NP-1:0] s_pv;

    typedef struct {
        logic          r, cv, s;
        logic          busy, done;
        logic [NP-1:0] pv;
        logic          pbit;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic cv, input logic s, input logic b,
                       input logic d, input logic [NP-1:0] pv, input logic pb);
        vec_t v;
        v.r = r; v.cv = cv; v.s = s; v.busy = b; v.done = d; v.pv = pv; v.pbit = pb;
        tbl.push_back(v);
    endtask

    task automatic step(input logic r, input logic cv, input logic s);
        logic          in_d, e_done, e_busy, e_pbit;
        logic [NP-1:0] e_pv;
        logic [13:0]   act, exp;
        rst = r; collectvalid = cv; serIn = s;
        @(negedge clk);
        e_busy = (m_off >= 1);
        in_d   = (m_off >= D0) && (m_off < D0 + m_len);
        e_pv   = '0;
        if (in_d) e_pv[m_addr] = 1'b1;
        e_pbit = in_d & s;
        e_done = (m_off >= D0) && (m_off == D0 + m_len);
        act = {detect, done, busy, port_valid, port_bit, addr_q, len_q};
        exp = {e_done, e_done, e_busy, e_pv, e_pbit, AW'(m_addr), LW'(m_len)};
        vec_cnt++;
        if (act !== exp) begin
            miss++;
            $display("FAIL cycle t=%0t off=%0d: got det,done,busy,pv,pbit,addr,len=%b,%b,%b,%b,%b,%0d,%0d want %b,%b,%b,%b,%b,%0d,%0d",
                     $time, m_off, detect, done, busy, port_valid, port_bit, addr_q, len_q,
                     e_done, e_done, e_busy, e_pv, e_pbit, m_addr, m_len);
        end
        s_busy = busy; s_done = done; s_pv = port_valid; s_pbit = port_bit;
        if (done === 1'b1) done_seen++;
        @(posedge clk);
        if (!r) begin
            m_off = -1; m_addr = 0; m_len = 0;
        end else if (m_off < 0) begin
            if (cv) m_off = 1;
        end else begin
            if (m_off <= AW)           m_addr = (m_addr * 2 + int'(s)) % NP;
            else if (m_off <= AW + LW) m_len  = (m_len * 2 + int'(s)) % (2**LW);
            if (m_off >= D0 && m_off == D0 + m_len) m_off = -1;
            else m_off++;
        end
        #1;
    endtask

    task automatic send_frame(input int addr, input int len, input int rst_at, input int spur_at);
        logic s;
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int off = 1; off <= D0 + len; off++) begin
            if (off <= AW)           s = 1'((addr >> (AW - off)) & 1);
            else if (off <= AW + LW) s = 1'((len >> (LW - (off - AW))) & 1);
            else                     s = 1'($urandom);
            step((off == rst_at) ? 1'b0 : 1'b1, (off == spur_at), s);
            if (off == rst_at) return;
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        vec_cnt++;
        if (got != want) begin
            miss++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        int d0;
        int len, ra, sp;
        rst = 1'b0; collectvalid = 1'b0; serIn = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with toggling serIn, idle hold, then frame addr=10 len=0011 payload 1,0,1.
        add(0,0,1, 0,0,4'b0000,0);
        add(0,0,0, 0,0,4'b0000,0);
        add(1,0,1, 0,0,4'b0000,0);
        add(1,0,0, 0,0,4'b0000,0);
        add(1,0,1, 0,0,4'b0000,0);
        add(1,0,0, 0,0,4'b0000,0);
        for (int i = 0; i < 5; i++) add(1,0,1, 0,0,4'b0000,0);
        add(1,1,0, 0,0,4'b0000,0);
        add(1,0,1, 1,0,4'b0000,0);
        add(1,0,0, 1,0,4'b0000,0);
        add(1,0,0, 1,0,4'b0000,0);
        add(1,0,0, 1,0,4'b0000,0);
        add(1,0,1, 1,0,4'b0000,0);
        add(1,0,1, 1,0,4'b0000,0);
        add(1,0,1, 1,0,4'b0100,1);
        add(1,0,0, 1,0,4'b0100,0);
        add(1,0,1, 1,0,4'b0100,1);
        add(1,0,0, 1,1,4'b0000,0);
        add(1,0,1, 0,0,4'b0000,0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].cv, tbl[i].s);
            vec_cnt++;
            if ({s_busy, s_done, s_pv, s_pbit} !== {tbl[i].busy, tbl[i].done, tbl[i].pv, tbl[i].pbit}) begin
                miss++;
                $display("FAIL table row %0d: got busy,done,pv,pbit=%b,%b,%b,%b want %b,%b,%b,%b",
                         i, s_busy, s_done, s_pv, s_pbit,
                         tbl[i].busy, tbl[i].done, tbl[i].pv, tbl[i].pbit);
            end
        end
        check_val("addr_after_frame", int'(addr_q), 2);
        check_val("len_after_frame", int'(len_q), 3);

        // Zero-length frame.
        send_frame(1, 0, -1, -1);
        step(1'b1, 1'b0, 1'b1);
        check_val("addr_len0", int'(addr_q), 1);
        check_val("len_len0", int'(len_q), 0);

        // Maximum length.
        send_frame(3, 15, -1, -1);
        step(1'b1, 1'b0, 1'b0);

        // Reset during the second payload bit of frame 2, then a normal frame.
        send_frame(2, 5, -1, -1);
        d0 = done_seen;
        send_frame(1, 6, 8, -1);
        step(1'b1, 1'b0, 1'b1);
        check_val("done_after_abort", done_seen - d0, 0);
        send_frame(0, 1, -1, -1);

        // Back-to-back frames with a spurious collectvalid in DATA.
        d0 = done_seen;
        send_frame(2, 3, -1, 8);
        send_frame(1, 2, -1, 7);
        check_val("done_back_to_back", done_seen - d0, 2);

        // Random frames, idle noise, spurious pulses and occasional resets.
        repeat (40) begin
            repeat ($urandom_range(0, 3)) step(($urandom % 10 == 0) ? 1'b0 : 1'b1, 1'b0, 1'($urandom));
            len = $urandom_range(0, 15);
            ra  = ($urandom % 6 == 0) ? $urandom_range(1, D0 + len) : -1;
            sp  = ($urandom % 3 == 0) ? $urandom_range(1, D0 + len) : -1;
            send_frame($urandom_range(0, 3), len, ra, sp);
        end
        step(1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
        $finish;
    end

endmodule
